pll_phase_ctrl: RTL and testbench

// - Initiator for the PLL dynamic phase-shift port (PHASE_SEL/PHASE_DIR/PHASE_STEP_N/LOAD_PHASE).
// - Accepts one request at a time: "shift clkout<sel> by N fine steps, direction dir".
// - Converts each request into timed step pulses plus a final load strobe.
// - Sits in the clkin1 domain beside the PLL wrapper, which drives its port inputs statically today.

---
 rtl/pll_pkg.sv | 31 +++
 rtl/pll_lock_sync.sv | 28 ++
 rtl/pll_phase_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// pll_pkg: shared types and constants for the PLL dynamic phase-shift initiator.
//   ph_state_t   - sequencer states
//   PHASE_SEL_W  - width of the PLL PHASE_SEL field
//   PHASE_POS_W  - width of each per-output signed step-position counter
//   max3/cnt_w   - helpers for sizing the shared step-timing counter
package pll_pkg;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STEP_LO,
        PH_STEP_HI,
        PH_LOAD,
        PH_FIN
    } ph_state_t;

    localparam int PHASE_SEL_W = 3;
    localparam int PHASE_POS_W = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A counter that must hold 0..m-1; never narrower than one bit.
    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchroniser for the asynchronous PLL lock signal.
//   i_clk   - destination clock
//   i_rst   - asynchronous active-high reset, clears both flops
//   i_async - asynchronous input (PLL lock)
//   o_sync  - synchronised copy, two cycles of latency
module pll_lock_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: drives the PLL dynamic phase-shift port. Each accepted request
// "shift output sel by N fine steps in direction dir" becomes a setup hold, N
// timed active-low step pulses and a final one-cycle load strobe.
//   i_clk, i_rst         - clock (PLL reference domain), async active-high reset
//   i_pll_lock           - asynchronous PLL lock, synchronised internally
//   i_req_*/o_req_ready  - single-request valid/ready handshake
//   o_busy/o_done/o_err  - status; done and err are one-cycle pulses
//   o_phase_sel/dir/step_n, o_load_phase - PLL phase-shift port
//   o_phase_pos          - per-output signed step positions
// Build option: define PLL_PHASE_TRACK_EN to keep a 16-bit signed step
// position per output; otherwise o_phase_pos is tied to zero.
module pll_phase_ctrl
    import pll_pkg::*;
#(
    parameter int NUM_OUT   = 5,
    parameter int STEP_W    = 8,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_pll_lock,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [PHASE_SEL_W-1:0]         i_req_sel,
    input  logic                           i_req_dir,
    input  logic [STEP_W-1:0]              i_req_steps,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_err,
    output logic [PHASE_SEL_W-1:0]         o_phase_sel,
    output logic                           o_phase_dir,
    output logic                           o_phase_step_n,
    output logic                           o_load_phase,
    output logic [NUM_OUT*PHASE_POS_W-1:0] o_phase_pos
);

    localparam int CNT_W = cnt_w(max3(SETUP_CYC, PULSE_CYC, GAP_CYC));
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    ph_state_t               r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [STEP_W-1:0]       r_rem;
    logic                    r_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [PHASE_SEL_W-1:0]  r_sel;
    logic                    r_dir;
    logic                    r_step_n;
    logic                    r_load;
    logic                    w_lock_s;
    logic                    w_abort;

    pll_lock_sync u_lock_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_pll_lock),
        .o_sync  (w_lock_s)
    );

    // Lock loss only aborts while the PLL port is being exercised; FIN has
    // already committed the done pulse.
    assign w_abort = !w_lock_s &&
                     (r_state inside {PH_SETUP, PH_STEP_LO, PH_STEP_HI, PH_LOAD});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= PH_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_sel    <= '0;
            r_dir    <= 1'b0;
            r_step_n <= 1'b1;
            r_load   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_abort) begin
                r_state  <= PH_IDLE;
                r_step_n <= 1'b1;
                r_load   <= 1'b0;
                r_err    <= 1'b1;
                r_busy   <= 1'b0;
                r_ready  <= 1'b0;
            end else begin
                case (r_state)
                    PH_IDLE: begin
                        r_ready <= w_lock_s;
                        if (i_req_valid && r_ready) begin
                            if (int'(i_req_sel) >= NUM_OUT) begin
                                // Rejected: stay idle, PLL port untouched.
                                r_err <= 1'b1;
                            end else if (i_req_steps == '0) begin
                                r_state <= PH_FIN;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b1;
                                r_ready <= 1'b0;
                            end else begin
                                r_state <= PH_SETUP;
                                r_cnt   <= SETUP_LD;
                                r_sel   <= i_req_sel;
                                r_dir   <= i_req_dir;
                                r_rem   <= i_req_steps;
                                r_busy  <= 1'b1;
                                r_ready <= 1'b0;
                            end
                        end
                    end
                    PH_SETUP: begin
                        if (r_cnt == '0) begin
                            r_state  <= PH_STEP_LO;
                            r_step_n <= 1'b0;
                            r_cnt    <= PULSE_LD;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    PH_STEP_LO: begin
                        if (r_cnt == '0) begin
                            r_state  <= PH_STEP_HI;
                            r_step_n <= 1'b1;
                            r_cnt    <= GAP_LD;
                            r_rem    <= r_rem - 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    PH_STEP_HI: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (r_rem == '0) begin
                            r_state <= PH_LOAD;
                            r_load  <= 1'b1;
                        end else begin
                            r_state  <= PH_STEP_LO;
                            r_step_n <= 1'b0;
                            r_cnt    <= PULSE_LD;
                        end
                    end
                    PH_LOAD: begin
                        r_state <= PH_FIN;
                        r_load  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    PH_FIN: begin
                        r_state <= PH_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= w_lock_s;
                    end
                    default: r_state <= PH_IDLE;
                endcase
            end
        end
    end

`ifdef PLL_PHASE_TRACK_EN
    logic [NUM_OUT-1:0][PHASE_POS_W-1:0] r_pos;
    logic                                w_step_end;

    // A step counts when its low pulse runs to completion (rising edge that
    // ends STEP_LO); a pulse truncated by an abort does not count.
    assign w_step_end = (r_state == PH_STEP_LO) && (r_cnt == '0) && !w_abort;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pos <= '0;
        end else if (w_step_end) begin
            // +1 for advance, all-ones (-1) for retard; wraps naturally.
            r_pos[r_sel] <= r_pos[r_sel] + {{(PHASE_POS_W-1){~r_dir}}, 1'b1};
        end
    end

    assign o_phase_pos = r_pos;
`else
    assign o_phase_pos = '0;
`endif

    assign o_req_ready    = r_ready;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_phase_sel    = r_sel;
    assign o_phase_dir    = r_dir;
    assign o_phase_step_n = r_step_n;
    assign o_load_phase   = r_load;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl: randomized self-checking bench for pll_phase_ctrl.
// Expected port values per cycle after a handshake come from a timing model
// that derives each signal from the request and its cycle offset.
module tb_pll_phase_ctrl;

    localparam int NUM_OUT = 5;
    localparam int S = 2;
    localparam int P = 4;
    localparam int G = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lock = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  sel = '0;
    logic        dir = 1'b0;
    logic [7:0]  steps = '0;
    logic        ready, busy, done, err, pdir, step_n, load;
    logic [2:0]  psel;
    logic [79:0] pos;

    int total = 0;
    int bad = 0;

    logic [9:0]  obs [0:127];
    logic [15:0] mpos [0:NUM_OUT-1];
    logic [2:0]  hsel = '0;
    logic        hdir = 1'b0;

    localparam logic [9:0] RST_VEC = 10'b0000_1_0_0_000;

    pll_phase_ctrl #(
        .NUM_OUT(NUM_OUT), .STEP_W(8), .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_pll_lock(lock),
        .i_req_valid(valid), .o_req_ready(ready),
        .i_req_sel(sel), .i_req_dir(dir), .i_req_steps(steps),
        .o_busy(busy), .o_done(done), .o_err(err),
        .o_phase_sel(psel), .o_phase_dir(pdir), .o_phase_step_n(step_n),
        .o_load_phase(load), .o_phase_pos(pos)
    );

    always #5 clk = ~clk;

    // Expected {ready,busy,done,err,step_n,load,phase_dir,phase_sel} in cycle k
    // after the handshake edge. kab>0 is the cycle at which an abort shows.
    function automatic logic [9:0] model(input int k, input int s, input bit d,
                                         input int n, input int kab,
                                         input logic [2:0] hs, input logic hd);
        logic rdy, bsy, dn, er, sn, ld, pd;
        logic [2:0] ps;
        int len, off;
        rdy = 0; bsy = 0; dn = 0; er = 0; sn = 1; ld = 0; ps = hs; pd = hd;
        if (s >= NUM_OUT) begin
            rdy = 1;
            er  = (k == 1);
        end else if (n == 0) begin
            bsy = (k == 1);
            dn  = (k == 1);
            rdy = (k >= 2);
        end else begin
            ps  = 3'(s);
            pd  = d;
            len = 2 + S + n * (P + G);
            if (kab > 0 && k >= kab) begin
                er = (k == kab);
            end else begin
                bsy = (k <= len);
                rdy = (k > len);
                dn  = (k == len);
                ld  = (k == len - 1);
                off = k - 1 - S;
                sn  = !(off >= 0 && off < n * (P + G) && (off % (P + G)) < P);
            end
        end
        return {rdy, bsy, dn, er, sn, ld, pd, ps};
    endfunction

    function automatic logic [79:0] exp_pos();
        logic [79:0] v;
        v = '0;
`ifdef PLL_PHASE_TRACK_EN
        for (int i = 0; i < NUM_OUT; i++) v[16*i +: 16] = mpos[i];
`endif
        return v;
    endfunction

    function automatic void model_steps(input int s, input bit d, input int n);
        if (d) mpos[s] = mpos[s] + 16'(n);
        else   mpos[s] = mpos[s] - 16'(n);
    endfunction

    // Wait (bounded) for ready, handshake one request, then record ncyc cycles.
    task automatic issue(input logic [2:0] s, input logic d, input logic [7:0] n,
                         input int ncyc, input bit noise, input int nz_end,
                         input int kdrop, output bit ok);
        ok = 0;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) return;
        valid = 1; sel = s; dir = d; steps = n;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            obs[k] = {ready, busy, done, err, step_n, load, pdir, psel};
            if (noise && k < nz_end) begin
                valid = 1; sel = 3'($urandom); dir = 1'($urandom); steps = 8'($urandom);
            end else begin
                valid = 0;
            end
            if (k == kdrop) lock = 0;
        end
        valid = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_OUT; i++) mpos[i] = '0;
        #1 rst = 1;
        #2;
        total++;
        if ({ready, busy, done, err, step_n, load, pdir, psel} !== RST_VEC || pos !== '0) begin
            bad++;
            $display("FAIL reset_async got=%b pos=%h want=%b pos=0",
                     {ready, busy, done, err, step_n, load, pdir, psel}, pos, RST_VEC);
        end
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_nolock got=%b want=0", ready);
        end
        lock = 1;
        repeat (3) @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_lock got=%b want=1", ready);
        end
    endtask

    task automatic test_track();
        bit ok;
        logic [9:0] e;
        int ns [2] = '{5, 7};
        bit ds [2] = '{1'b1, 1'b0};
        for (int r = 0; r < 2; r++) begin
            issue(3'd1, ds[r], 8'(ns[r]), 2 + 2 + S + ns[r] * (P + G), 0, 0, 0, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL track_ready got=0 want=1");
            end else begin
                for (int k = 1; k <= 2 + 2 + S + ns[r] * (P + G); k++) begin
                    e = model(k, 1, ds[r], ns[r], 0, hsel, hdir);
                    total++;
                    if (obs[k] !== e) begin
                        bad++;
                        $display("FAIL track_cyc%0d got=%b want=%b", k, obs[k], e);
                    end
                end
                hsel = 3'd1; hdir = ds[r];
                model_steps(1, ds[r], ns[r]);
            end
        end
        total++;
`ifdef PLL_PHASE_TRACK_EN
        if (pos[31:16] !== 16'hFFFE || {pos[79:32], pos[15:0]} !== '0) begin
            bad++;
            $display("FAIL track_pos got=%h want out1=fffe others=0", pos);
        end
`else
        if (pos !== '0) begin
            bad++;
            $display("FAIL track_pos_off got=%h want=0", pos);
        end
`endif
    endtask

    task automatic test_basic();
        bit ok;
        logic [9:0] e;
        issue(3'd2, 1'b1, 8'd3, 42, 0, 0, 0, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_ready got=0 want=1");
            return;
        end
        for (int k = 1; k <= 42; k++) begin
            e = model(k, 2, 1'b1, 3, 0, hsel, hdir);
            total++;
            if (obs[k] !== e) begin
                bad++;
                $display("FAIL basic_cyc%0d got=%b want=%b", k, obs[k], e);
            end
        end
        hsel = 3'd2; hdir = 1'b1;
        model_steps(2, 1'b1, 3);
        total++;
        if (pos !== exp_pos()) begin
            bad++;
            $display("FAIL basic_pos got=%h want=%h", pos, exp_pos());
        end
    endtask

    task automatic test_zero_and_badsel();
        bit ok;
        logic [9:0] e;
        logic [2:0] ss [2] = '{3'd4, 3'd6};
        logic [7:0] nn [2] = '{8'd0, 8'd3};
        for (int r = 0; r < 2; r++) begin
            issue(ss[r], 1'b1, nn[r], 4, 0, 0, 0, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL edge%0d_ready got=0 want=1", r);
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    e = model(k, int'(ss[r]), 1'b1, int'(nn[r]), 0, hsel, hdir);
                    total++;
                    if (obs[k] !== e) begin
                        bad++;
                        $display("FAIL edge%0d_cyc%0d got=%b want=%b", r, k, obs[k], e);
                    end
                end
            end
        end
        total++;
        if (pos !== exp_pos()) begin
            bad++;
            $display("FAIL edge_pos got=%h want=%h", pos, exp_pos());
        end
    endtask

    task automatic test_random(input int iters);
        bit ok;
        logic [9:0] e;
        logic [2:0] s;
        logic d;
        logic [7:0] n;
        int len, nc;
        bit nz;
        for (int it = 0; it < iters; it++) begin
            s = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            d = 1'($urandom);
            n = 8'($urandom_range(0, 4));
            if (int'(s) < NUM_OUT && n != 0) begin
                len = 2 + S + int'(n) * (P + G); nc = len + 2; nz = 1;
            end else begin
                len = 0; nc = 3; nz = 0;
            end
            issue(s, d, n, nc, nz, len, 0, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rand%0d_ready got=0 want=1", it);
                continue;
            end
            for (int k = 1; k <= nc; k++) begin
                e = model(k, int'(s), d, int'(n), 0, hsel, hdir);
                total++;
                if (obs[k] !== e) begin
                    bad++;
                    $display("FAIL rand%0d_cyc%0d sel=%0d n=%0d got=%b want=%b",
                             it, k, s, n, obs[k], e);
                end
            end
            if (int'(s) < NUM_OUT && n != 0) begin
                hsel = s; hdir = d;
                model_steps(int'(s), d, int'(n));
            end
            total++;
            if (pos !== exp_pos()) begin
                bad++;
                $display("FAIL rand%0d_pos got=%h want=%h", it, pos, exp_pos());
            end
        end
    endtask

    task automatic test_lock_drop();
        bit ok;
        logic [9:0] e;
        int kdrop;
        kdrop = $urandom_range(19, 23);   // inside the gap of the 2nd step
        issue(3'd1, 1'b0, 8'd3, 42, 0, 0, kdrop, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL lock_ready got=0 want=1");
            lock = 1;
            return;
        end
        for (int k = 1; k <= 42; k++) begin
            e = model(k, 1, 1'b0, 3, kdrop + 3, hsel, hdir);
            total++;
            if (obs[k] !== e) begin
                bad++;
                $display("FAIL lock_cyc%0d drop=%0d got=%b want=%b", k, kdrop, obs[k], e);
            end
        end
        hsel = 3'd1; hdir = 1'b0;
        model_steps(1, 1'b0, 2);
        total++;
        if (pos !== exp_pos()) begin
            bad++;
            $display("FAIL lock_pos got=%h want=%h", pos, exp_pos());
        end
        lock = 1;
    endtask

    task automatic test_rst_mid();
        bit ok;
        logic [9:0] e;
        issue(3'd3, 1'b1, 8'd2, 4, 0, 0, 0, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstmid_ready got=0 want=1");
            return;
        end
        for (int k = 1; k <= 4; k++) begin
            e = model(k, 3, 1'b1, 2, 0, hsel, hdir);
            total++;
            if (obs[k] !== e) begin
                bad++;
                $display("FAIL rstmid_cyc%0d got=%b want=%b", k, obs[k], e);
            end
        end
        #2 rst = 1;
        #1;
        total++;
        if ({ready, busy, done, err, step_n, load, pdir, psel} !== RST_VEC || pos !== '0) begin
            bad++;
            $display("FAIL rstmid_async got=%b pos=%h want=%b pos=0",
                     {ready, busy, done, err, step_n, load, pdir, psel}, pos, RST_VEC);
        end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < NUM_OUT; i++) mpos[i] = '0;
        hsel = '0; hdir = 1'b0;
    endtask

    initial begin
        test_reset();
        test_track();
        test_basic();
        test_zero_and_badsel();
        test_random(6);
        test_lock_drop();
        test_rst_mid();
        test_random(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
